multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle sequencer for the RISC-V datapath.
- Replaces the single-cycle opcode decode with an FSM that steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Shares one unified memory port between instruction fetch and load/store through a req/ready handshake.
- Produces all datapath enables and selects, plus a retired-instruction counter.

Parameters:
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- instr_opcode  in  7  opcode field from instruction register (IR).
- funct3  in  3  funct3 field from IR.
- EQ  in  1  ALU equality flag (operands equal).
- mem_ready  in  1  memory completes current request this cycle.
- mem_req  out  1  memory request valid.
- mem_we  out  1  request is a write (store).
- addr_src  out  1  memory address select: 0=PC, 1=ALU result register.
- ir_we  out  1  load IR from memory read data.
- pc_we  out  1  update PC.
- pc_src  out  1  next PC select: 0=PC+4, 1=old PC + immediate.
- reg_we  out  1  register file write enable.
- alu_ctrl  out  3  ALU operation.
- alu_src  out  1  ALU operand B select: 0=rs2, 1=immediate.
- imm_src  out  2  immediate format: 00=I, 01=S, 10=B.
- result_src  out  1  writeback select: 0=ALU result register, 1=latched memory data.
- illegal  out  1  sticky illegal-opcode flag.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- All state is updated on the rising edge of clk.
- Reset:
  - While rst_n=0 at a rising edge: next state=FETCH, illegal=0, retired=0.
  - While rst_n=0, all outputs are forced to 0 combinationally.
  - Reset asserted mid-handshake abandons the request; no write enable pulses in that cycle.
- Outputs are combinational from the current state and the IR fields. Any output not listed for a state is 0.
- Supported opcodes:
  - 0010011 OP-IMM
  - 0110011 OP
  - 0000011 LOAD
  - 0100011 STORE
  - 1100011 BRANCH (funct3 000 BEQ, 001 BNE)
- alu_ctrl map:
  - OP/OP-IMM: funct3 000→000 (add), 111→010 (and), 110→011 (or), other→000.
  - LOAD/STORE address calculation: 000.
  - BRANCH compare: 111.
- States (3-bit encoding): FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- FETCH:
  - mem_req=1, addr_src=0.
  - Holds until mem_ready=1.
  - On mem_ready cycle: ir_we=1, pc_we=1, pc_src=0; next state DECODE.
- DECODE:
  - One cycle, no enables.
  - Supported opcode (for BRANCH, funct3 000 or 001 only) → EXEC.
  - Anything else → TRAP, illegal set to 1.
- EXEC:
  - OP-IMM: alu_src=1, imm_src=00 → WB.
  - OP: alu_src=0 → WB.
  - LOAD: alu_src=1, imm_src=00 → MEM.
  - STORE: alu_src=1, imm_src=01 → MEM.
  - BRANCH: alu_src=0, imm_src=10. Taken = (funct3=000 & EQ) | (funct3=001 & !EQ).
  - BRANCH taken: pc_we=1, pc_src=1. Retired increments. Next state FETCH.
- MEM:
  - mem_req=1, addr_src=1; mem_we=1 for STORE.
  - Holds until mem_ready=1.
  - LOAD: → WB; datapath latches read data on the mem_ready cycle.
  - STORE: retired increments, → FETCH.
- WB:
  - reg_we=1 for exactly one cycle; result_src=1 for LOAD, 0 otherwise.
  - Retired increments, → FETCH.
- TRAP: all enables 0; held until reset.
- Handshake rules:
  - mem_req, mem_we and addr_src stay stable while waiting.
  - mem_ready is ignored when mem_req=0.
  - A stall of any length is legal.
- Retired counter wraps from 2^CNT_W-1 to 0.
- Cycle counts with mem_ready tied high:
  - OP/OP-IMM/LOAD-less ALU: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles.

Test Plan:
- Reset, then OP-IMM 0010011 funct3=000, mem_ready=1 → states 0,1,2,4,0; ir_we pulses at cycle 0, reg_we at cycle 3, alu_ctrl=000, alu_src=1; retired=1.
- LOAD with mem_ready low for 3 cycles in FETCH and 2 cycles in MEM → mem_req held high with addr_src=0, then with addr_src=1; reg_we with result_src=1 exactly once; total 10 cycles.
- STORE → MEM shows mem_req=1, mem_we=1, addr_src=1, imm_src=01 in EXEC; no reg_we; retired increments.
- BEQ with EQ=1 → pc_we=1, pc_src=1 in EXEC. BNE with EQ=1 → no pc_we in EXEC. Both return to FETCH after 3 cycles.
- Opcode 1111111, or BRANCH funct3=100 → TRAP, illegal=1 sticky, no further mem_req. rst_n=0 for one edge → FETCH, illegal=0.
- rst_n low during MEM wait of a STORE → all outputs 0 immediately, FETCH next; retired preloaded to 2^32-1 wraps to 0 on next completion.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the RISC-V datapath: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB over one shared memory port and counts retirements.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       instr_opcode,
    input  logic [2:0]       funct3,
    input  logic             EQ,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_src,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_src,
    output logic             reg_we,
    output logic [2:0]       alu_ctrl,
    output logic             alu_src,
    output logic [1:0]       imm_src,
    output logic             result_src,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    state_t           state;
    logic             illegal_q;
    logic [CNT_W-1:0] retired_q;

    logic is_alu, is_op_imm, is_load, is_store, is_branch;
    logic legal, taken;
    logic [2:0] alu_fn;

    assign is_op_imm = (instr_opcode == OPC_OP_IMM);
    assign is_alu    = is_op_imm || (instr_opcode == OPC_OP);
    assign is_load   = (instr_opcode == OPC_LOAD);
    assign is_store  = (instr_opcode == OPC_STORE);
    assign is_branch = (instr_opcode == OPC_BRANCH);

    // Only BEQ and BNE are implemented; other branch flavours trap.
    assign legal = is_alu || is_load || is_store ||
                   (is_branch && (funct3 == 3'b000 || funct3 == 3'b001));
    assign taken = ((funct3 == 3'b000) && EQ) || ((funct3 == 3'b001) && !EQ);

    always_comb begin
        case (funct3)
            3'b111:  alu_fn = 3'b010;
            3'b110:  alu_fn = 3'b011;
            default: alu_fn = 3'b000;
        endcase
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= FETCH;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (mem_ready) state <= DECODE;
                end
                DECODE: begin
                    if (legal) begin
                        state <= EXEC;
                    end else begin
                        state     <= TRAP;
                        illegal_q <= 1'b1;
                    end
                end
                EXEC: begin
                    if (is_load || is_store) begin
                        state <= MEM;
                    end else if (is_branch) begin
                        state     <= FETCH;
                        retired_q <= retired_q + CNT_W'(1);
                    end else begin
                        state <= WB;
                    end
                end
                MEM: begin
                    if (mem_ready) begin
                        if (is_store) begin
                            state     <= FETCH;
                            retired_q <= retired_q + CNT_W'(1);
                        end else begin
                            state <= WB;
                        end
                    end
                end
                WB: begin
                    state     <= FETCH;
                    retired_q <= retired_q + CNT_W'(1);
                end
                TRAP:    state <= TRAP;
                default: state <= FETCH;
            endcase
        end
    end

    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_src   = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 1'b0;
        reg_we     = 1'b0;
        alu_ctrl   = 3'b000;
        alu_src    = 1'b0;
        imm_src    = 2'b00;
        result_src = 1'b0;
        illegal    = 1'b0;
        retired    = '0;
        // Reset masks everything, so an abandoned handshake cannot fire an enable.
        if (rst_n) begin
            illegal = illegal_q;
            retired = retired_q;
            case (state)
                FETCH: begin
                    mem_req = 1'b1;
                    ir_we   = mem_ready;
                    pc_we   = mem_ready;
                end
                EXEC: begin
                    if (is_alu) begin
                        alu_ctrl = alu_fn;
                        alu_src  = is_op_imm;
                    end else if (is_load) begin
                        alu_src = 1'b1;
                    end else if (is_store) begin
                        alu_src = 1'b1;
                        imm_src = 2'b01;
                    end else if (is_branch) begin
                        alu_ctrl = 3'b111;
                        imm_src  = 2'b10;
                        pc_we    = taken;
                        pc_src   = taken;
                    end
                end
                MEM: begin
                    mem_req  = 1'b1;
                    addr_src = 1'b1;
                    mem_we   = is_store;
                end
                WB: begin
                    reg_we     = 1'b1;
                    result_src = is_load;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected control words are
// queued by the stimulus and compared by an independent negedge monitor.
module tb_multicycle_control;

    typedef logic [14:0] cw_t;

    typedef struct {
        string       name;
        cw_t         ctl;
        logic [31:0] ret;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [6:0]  instr_opcode;
    logic [2:0]  funct3;
    logic        EQ;
    logic        mem_ready;

    logic        mem_req, mem_we, addr_src, ir_we, pc_we, pc_src, reg_we;
    logic [2:0]  alu_ctrl;
    logic        alu_src;
    logic [1:0]  imm_src;
    logic        result_src, illegal;
    logic [31:0] retired;

    logic        s_mem_req, s_mem_we, s_addr_src, s_ir_we, s_pc_we, s_pc_src, s_reg_we;
    logic [2:0]  s_alu_ctrl;
    logic        s_alu_src;
    logic [1:0]  s_imm_src;
    logic        s_result_src, s_illegal;
    logic [1:0]  s_retired;

    int          checks = 0;
    int          failures = 0;
    exp_t        exp_q[$];
    exp_t        e;
    logic [31:0] ret_exp;
    cw_t         ctl_act, s_ctl_act;

    multicycle_control #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .instr_opcode(instr_opcode), .funct3(funct3),
        .EQ(EQ), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .addr_src(addr_src), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
        .reg_we(reg_we), .alu_ctrl(alu_ctrl), .alu_src(alu_src), .imm_src(imm_src),
        .result_src(result_src), .illegal(illegal), .retired(retired)
    );

    // Narrow counter copy driven identically, so its retired count wraps quickly.
    multicycle_control #(.CNT_W(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .instr_opcode(instr_opcode), .funct3(funct3),
        .EQ(EQ), .mem_ready(mem_ready), .mem_req(s_mem_req), .mem_we(s_mem_we),
        .addr_src(s_addr_src), .ir_we(s_ir_we), .pc_we(s_pc_we), .pc_src(s_pc_src),
        .reg_we(s_reg_we), .alu_ctrl(s_alu_ctrl), .alu_src(s_alu_src), .imm_src(s_imm_src),
        .result_src(s_result_src), .illegal(s_illegal), .retired(s_retired)
    );

    assign ctl_act = {mem_req, mem_we, addr_src, ir_we, pc_we, pc_src, reg_we,
                      alu_ctrl, alu_src, imm_src, result_src, illegal};
    assign s_ctl_act = {s_mem_req, s_mem_we, s_addr_src, s_ir_we, s_pc_we, s_pc_src, s_reg_we,
                        s_alu_ctrl, s_alu_src, s_imm_src, s_result_src, s_illegal};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({e.name, " ctl"}, 64'(ctl_act), 64'(e.ctl));
            check({e.name, " retired"}, 64'(retired), 64'(e.ret));
            check({e.name, " ctl_w2"}, 64'(s_ctl_act), 64'(e.ctl));
            check({e.name, " retired_w2"}, 64'(s_retired), 64'(e.ret[1:0]));
        end
    end

    // Control word: req we asel irwe pcwe pcsrc regwe alu[3] bsel imm[2] res ill
    function automatic cw_t cw(input logic req, input logic we, input logic asel,
                               input logic irw, input logic pcw, input logic pcs,
                               input logic rw, input logic [2:0] alu, input logic bsel,
                               input logic [1:0] imm, input logic res, input logic ill);
        return {req, we, asel, irw, pcw, pcs, rw, alu, bsel, imm, res, ill};
    endfunction

    function automatic cw_t k_zero();
        return cw(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 2'b00, 0, 0);
    endfunction
    function automatic cw_t k_fwait();
        return cw(1, 0, 0, 0, 0, 0, 0, 3'b000, 0, 2'b00, 0, 0);
    endfunction
    function automatic cw_t k_fgo();
        return cw(1, 0, 0, 1, 1, 0, 0, 3'b000, 0, 2'b00, 0, 0);
    endfunction
    function automatic cw_t k_ex(input logic [2:0] alu, input logic bsel,
                                 input logic [1:0] imm, input logic pcw, input logic pcs);
        return cw(0, 0, 0, 0, pcw, pcs, 0, alu, bsel, imm, 0, 0);
    endfunction
    function automatic cw_t k_mem(input logic we);
        return cw(1, we, 1, 0, 0, 0, 0, 3'b000, 0, 2'b00, 0, 0);
    endfunction
    function automatic cw_t k_wb(input logic res);
        return cw(0, 0, 0, 0, 0, 0, 1, 3'b000, 0, 2'b00, res, 0);
    endfunction
    function automatic cw_t k_trap();
        return cw(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 2'b00, 0, 1);
    endfunction

    task automatic step(input string name, input logic rstn, input logic [6:0] op,
                        input logic [2:0] f3, input logic eq, input logic rdy,
                        input cw_t c, input logic [31:0] r);
        exp_t x;
        rst_n        = rstn;
        instr_opcode = op;
        funct3       = f3;
        EQ           = eq;
        mem_ready    = rdy;
        x.name = name;
        x.ctl  = c;
        x.ret  = r;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic run_alu(input string n, input logic [6:0] op, input logic [2:0] f3,
                           input logic [2:0] alu, input logic bsel);
        step({n, " fetch"},  1, op, f3, 0, 1, k_fgo(), ret_exp);
        step({n, " decode"}, 1, op, f3, 0, 1, k_zero(), ret_exp);
        step({n, " exec"},   1, op, f3, 0, 1, k_ex(alu, bsel, 2'b00, 0, 0), ret_exp);
        step({n, " wb"},     1, op, f3, 0, 1, k_wb(0), ret_exp);
        ret_exp++;
    endtask

    task automatic run_br(input string n, input logic [2:0] f3, input logic eq,
                          input logic tk);
        step({n, " fetch"},  1, 7'b1100011, f3, eq, 1, k_fgo(), ret_exp);
        step({n, " decode"}, 1, 7'b1100011, f3, eq, 1, k_zero(), ret_exp);
        step({n, " exec"},   1, 7'b1100011, f3, eq, 1, k_ex(3'b111, 0, 2'b10, tk, tk), ret_exp);
        ret_exp++;
    endtask

    task automatic run_trap(input string n, input logic [6:0] op, input logic [2:0] f3);
        step({n, " fetch"},  1, op, f3, 0, 1, k_fgo(), ret_exp);
        step({n, " decode"}, 1, op, f3, 0, 1, k_zero(), ret_exp);
        for (int i = 0; i < 3; i++)
            step({n, " trap"}, 1, op, f3, 0, 1, k_trap(), ret_exp);
        step({n, " reset"}, 0, op, f3, 0, 1, k_zero(), 32'd0);
        ret_exp = 32'd0;
    endtask

    initial begin
        rst_n        = 1'b0;
        instr_opcode = 7'd0;
        funct3       = 3'd0;
        EQ           = 1'b0;
        mem_ready    = 1'b0;
        ret_exp      = 32'd0;
        @(posedge clk);
        #1;

        step("reset0", 0, 7'b0010011, 3'b000, 0, 1, k_zero(), 32'd0);
        step("reset1", 0, 7'b0010011, 3'b000, 0, 1, k_zero(), 32'd0);

        run_alu("addi", 7'b0010011, 3'b000, 3'b000, 1);
        run_alu("and",  7'b0110011, 3'b111, 3'b010, 0);

        for (int i = 0; i < 3; i++)
            step("lw fetch_wait", 1, 7'b0000011, 3'b010, 0, 0, k_fwait(), ret_exp);
        step("lw fetch",  1, 7'b0000011, 3'b010, 0, 1, k_fgo(), ret_exp);
        step("lw decode", 1, 7'b0000011, 3'b010, 0, 1, k_zero(), ret_exp);
        step("lw exec",   1, 7'b0000011, 3'b010, 0, 1, k_ex(3'b000, 1, 2'b00, 0, 0), ret_exp);
        for (int i = 0; i < 2; i++)
            step("lw mem_wait", 1, 7'b0000011, 3'b010, 0, 0, k_mem(0), ret_exp);
        step("lw mem",    1, 7'b0000011, 3'b010, 0, 1, k_mem(0), ret_exp);
        step("lw wb",     1, 7'b0000011, 3'b010, 0, 1, k_wb(1), ret_exp);
        ret_exp++;

        step("sw fetch",  1, 7'b0100011, 3'b010, 0, 1, k_fgo(), ret_exp);
        step("sw decode", 1, 7'b0100011, 3'b010, 0, 1, k_zero(), ret_exp);
        step("sw exec",   1, 7'b0100011, 3'b010, 0, 1, k_ex(3'b000, 1, 2'b01, 0, 0), ret_exp);
        step("sw mem",    1, 7'b0100011, 3'b010, 0, 1, k_mem(1), ret_exp);
        ret_exp++;

        run_br("beq_eq1", 3'b000, 1, 1);
        run_br("bne_eq1", 3'b001, 1, 0);
        run_br("bne_eq0", 3'b001, 0, 1);
        run_alu("or",   7'b0110011, 3'b110, 3'b011, 0);
        run_alu("xori", 7'b0010011, 3'b100, 3'b000, 1);

        step("sw2 fetch",    1, 7'b0100011, 3'b010, 0, 1, k_fgo(), ret_exp);
        step("sw2 decode",   1, 7'b0100011, 3'b010, 0, 1, k_zero(), ret_exp);
        step("sw2 exec",     1, 7'b0100011, 3'b010, 0, 1, k_ex(3'b000, 1, 2'b01, 0, 0), ret_exp);
        step("sw2 mem_wait", 1, 7'b0100011, 3'b010, 0, 0, k_mem(1), ret_exp);
        step("sw2 reset",    0, 7'b0100011, 3'b010, 0, 1, k_zero(), 32'd0);
        ret_exp = 32'd0;
        step("post_reset fetch_wait", 1, 7'b0100011, 3'b010, 0, 0, k_fwait(), ret_exp);

        run_trap("bad_opcode", 7'b1111111, 3'b000);
        run_trap("bad_branch", 7'b1100011, 3'b100);

        run_alu("addi_final", 7'b0010011, 3'b000, 3'b000, 1);
        step("idle fetch_wait", 1, 7'b0010011, 3'b000, 0, 0, k_fwait(), ret_exp);

        @(posedge clk);
        @(posedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
